// File: rtl/draw_pkg.sv
// Shared definitions for the draw command sequencer: opcodes, FSM state
// encoding and the packed command record carried through the command FIFO.
package draw_pkg;

  localparam logic [1:0] OP_POINT  = 2'd0;
  localparam logic [1:0] OP_LINE   = 2'd1;
  localparam logic [1:0] OP_CIRCLE = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  // Widest colour the command record can carry; narrower colours are
  // zero-extended on entry and truncated on exit.
  localparam int MAX_COLOR_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_EMIT = 3'd2,
    ST_RUN  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  typedef struct packed {
    logic [1:0]             op;
    logic [7:0]             x0;
    logic [7:0]             y0;
    logic [7:0]             x1;
    logic [7:0]             y1;
    logic [MAX_COLOR_W-1:0] color;
  } cmd_t;

endpackage

// File: rtl/draw_cmd_fifo.sv
// Single-clock command FIFO. DEPTH must be a power of two so the read and
// write pointers wrap naturally. Storage is not reset; only the pointers and
// the occupancy count are.
import draw_pkg::*;

module draw_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t wr_data,
  input  logic pop,
  output cmd_t rd_data,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Write the incoming command into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Advance pointers and track occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/draw_cmd_sequencer.sv
// Draw command sequencer: buffers host commands, dispatches them one at a
// time to the line or circle unit, and forwards the active unit's pixels
// onto a single registered pixel bus.
// Optional feature macro: DRAW_CLIP_EN -- when defined, pixels outside
// SCREEN_W x SCREEN_H are emitted with pix_valid low (timing unchanged).
//
// Command handshake: a command transfers on any rising ACLK edge where
// cmd_valid and cmd_ready are both high. cmd_ready is combinational from
// the FIFO occupancy only (high whenever the FIFO is not full), so it never
// depends on cmd_valid. The pixel bus has no back-pressure.
import draw_pkg::*;

module draw_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int COLOR_W    = 8,
  parameter int TIMEOUT    = 1024,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [7:0]         cmd_x0,
  input  logic [7:0]         cmd_y0,
  input  logic [7:0]         cmd_x1,
  input  logic [7:0]         cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic [7:0]         unit_x0,
  output logic [7:0]         unit_y0,
  output logic [7:0]         unit_x1,
  output logic [7:0]         unit_y1,
  output logic               line_en,
  output logic               circle_en,
  input  logic [7:0]         line_x,
  input  logic [7:0]         line_y,
  input  logic [7:0]         circle_x,
  input  logic [7:0]         circle_y,
  input  logic               line_finish,
  input  logic               circle_finish,
  output logic               pix_valid,
  output logic [7:0]         pix_x,
  output logic [7:0]         pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               busy,
  output logic               err_op,
  output logic               err_timeout,
  output logic [2:0]         dbg_state
);

  cmd_t               fifo_in;
  cmd_t               fifo_out;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  state_t             state;
  logic [1:0]         act_op;
  logic [COLOR_W-1:0] act_color;
  logic [15:0]        wdog;
  logic               wdog_expired;
  logic [7:0]         sel_x;
  logic [7:0]         sel_y;
  logic               sel_finish;
  logic               point_ok;
  logic               run_ok;

  assign cmd_ready    = !fifo_full;
  assign fifo_pop     = (state == ST_IDLE) && !fifo_empty;
  assign busy         = !fifo_empty || (state != ST_IDLE);
  assign wdog_expired = (wdog == 16'(TIMEOUT - 1));
  assign dbg_state    = state;

  // Pack the host command into the FIFO record.
  always_comb begin
    fifo_in       = '0;
    fifo_in.op    = cmd_op;
    fifo_in.x0    = cmd_x0;
    fifo_in.y0    = cmd_y0;
    fifo_in.x1    = cmd_x1;
    fifo_in.y1    = cmd_y1;
    fifo_in.color = MAX_COLOR_W'(cmd_color);
  end

  draw_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .push    (cmd_valid && cmd_ready),
    .wr_data (fifo_in),
    .pop     (fifo_pop),
    .rd_data (fifo_out),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Select the active unit's pixel stream and finish flag; the other unit is ignored.
  always_comb begin
    sel_x      = line_x;
    sel_y      = line_y;
    sel_finish = line_finish;
    if (act_op == OP_CIRCLE) begin
      sel_x      = circle_x;
      sel_y      = circle_y;
      sel_finish = circle_finish;
    end
  end

`ifdef DRAW_CLIP_EN
  assign point_ok = (int'(unit_x0) < SCREEN_W) && (int'(unit_y0) < SCREEN_H);
  assign run_ok   = (int'(sel_x) < SCREEN_W) && (int'(sel_y) < SCREEN_H);
`else
  assign point_ok = 1'b1;
  assign run_ok   = 1'b1;
`endif

  // Sequencer FSM: pop, load operands, run one unit, then a one-cycle enable gap.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state       <= ST_IDLE;
      act_op      <= OP_POINT;
      act_color   <= '0;
      unit_x0     <= '0;
      unit_y0     <= '0;
      unit_x1     <= '0;
      unit_y1     <= '0;
      line_en     <= 1'b0;
      circle_en   <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_color   <= '0;
      err_op      <= 1'b0;
      err_timeout <= 1'b0;
      wdog        <= '0;
    end else begin
      pix_valid   <= 1'b0;
      err_op      <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            act_op    <= fifo_out.op;
            act_color <= COLOR_W'(fifo_out.color);
            unit_x0   <= fifo_out.x0;
            unit_y0   <= fifo_out.y0;
            unit_x1   <= fifo_out.x1;
            unit_y1   <= fifo_out.y1;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          wdog <= '0;
          case (act_op)
            OP_POINT: begin
              pix_x     <= unit_x0;
              pix_y     <= unit_y0;
              pix_color <= act_color;
              pix_valid <= point_ok;
              state     <= ST_EMIT;
            end
            OP_LINE: begin
              line_en <= 1'b1;
              state   <= ST_RUN;
            end
            OP_CIRCLE: begin
              circle_en <= 1'b1;
              state     <= ST_RUN;
            end
            default: begin
              // Reserved opcode: drop the command.
              err_op <= 1'b1;
              state  <= ST_IDLE;
            end
          endcase
        end
        ST_EMIT: begin
          state <= ST_GAP;
        end
        ST_RUN: begin
          if (sel_finish) begin
            // The finishing cycle still carries a valid pixel.
            pix_x     <= sel_x;
            pix_y     <= sel_y;
            pix_color <= act_color;
            pix_valid <= run_ok;
            line_en   <= 1'b0;
            circle_en <= 1'b0;
            state     <= ST_GAP;
          end else if (wdog_expired) begin
            err_timeout <= 1'b1;
            line_en     <= 1'b0;
            circle_en   <= 1'b0;
            state       <= ST_GAP;
          end else begin
            pix_x     <= sel_x;
            pix_y     <= sel_y;
            pix_color <= act_color;
            pix_valid <= run_ok;
            wdog      <= wdog + 16'd1;
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_cmd_sequencer.sv
// Bench for draw_cmd_sequencer: behavioural line/circle unit models, a
// command-level reference model feeding an expected-event queue, and a
// monitor that pops and compares whenever the DUT shows an event.
`timescale 1ns/1ps
module tb_draw_cmd_sequencer;
  import draw_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int COLOR_W    = 8;
  localparam int TIMEOUT    = 32;
  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;

  localparam logic [1:0] K_PIX = 2'd0;
  localparam logic [1:0] K_OP  = 2'd1;
  localparam logic [1:0] K_TO  = 2'd2;

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESETn;
  always #5 ACLK = ~ACLK;

  logic               cmd_valid, cmd_ready;
  logic [1:0]         cmd_op;
  logic [7:0]         cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [COLOR_W-1:0] cmd_color;
  logic [7:0]         unit_x0, unit_y0, unit_x1, unit_y1;
  logic               line_en, circle_en;
  logic [7:0]         line_x, line_y, circle_x, circle_y;
  logic               line_finish, circle_finish;
  logic               pix_valid;
  logic [7:0]         pix_x, pix_y;
  logic [COLOR_W-1:0] pix_color;
  logic               busy, err_op, err_timeout;
  logic [2:0]         dbg_state;

  draw_cmd_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .COLOR_W    (COLOR_W),
    .TIMEOUT    (TIMEOUT),
    .SCREEN_W   (SCREEN_W),
    .SCREEN_H   (SCREEN_H)
  ) dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_x0        (cmd_x0),
    .cmd_y0        (cmd_y0),
    .cmd_x1        (cmd_x1),
    .cmd_y1        (cmd_y1),
    .cmd_color     (cmd_color),
    .unit_x0       (unit_x0),
    .unit_y0       (unit_y0),
    .unit_x1       (unit_x1),
    .unit_y1       (unit_y1),
    .line_en       (line_en),
    .circle_en     (circle_en),
    .line_x        (line_x),
    .line_y        (line_y),
    .circle_x      (circle_x),
    .circle_y      (circle_y),
    .line_finish   (line_finish),
    .circle_finish (circle_finish),
    .pix_valid     (pix_valid),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .pix_color     (pix_color),
    .busy          (busy),
    .err_op        (err_op),
    .err_timeout   (err_timeout),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [25:0] exp_q[$];   // {kind, x, y, color}
  logic [9:0]  en_q[$];    // {unit (1=line, 2=circle), enable length}
  bit          line_hang = 1'b0;
  bit          flushing  = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- unit models ----------------
  // Line: pixel k = (x0+k, y0+2k), finishes after ((x1^y1)&31)+1 cycles.
  // Circle: pixel k = (x0+k, y0-k), finishes after 4*R cycles (R=0 never).
  // Finish flags read high while the unit is disabled, so a sequencer that
  // watches the wrong unit ends its run early.
  int line_cnt, circ_cnt;
  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      line_cnt <= 0;
      circ_cnt <= 0;
    end else begin
      line_cnt <= line_en   ? line_cnt + 1 : 0;
      circ_cnt <= circle_en ? circ_cnt + 1 : 0;
    end
  end

  always_comb begin
    line_x        = unit_x0 + 8'(line_cnt);
    line_y        = unit_y0 + 8'(2 * line_cnt);
    line_finish   = line_en ? (!line_hang && line_cnt == int'((unit_x1 ^ unit_y1) & 8'd31)) : 1'b1;
    circle_x      = unit_x0 + 8'(circ_cnt);
    circle_y      = unit_y0 - 8'(circ_cnt);
    circle_finish = circle_en ? (unit_x1 != 8'd0 && circ_cnt == 4 * int'(unit_x1) - 1) : 1'b1;
  end

  // ---------------- reference model ----------------
  function automatic bit on_screen(input logic [7:0] x, input logic [7:0] y);
`ifdef DRAW_CLIP_EN
    return (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_cmd(input logic [1:0] op, input logic [7:0] x0, input logic [7:0] y0,
                           input logic [7:0] x1, input logic [7:0] y1, input logic [7:0] c);
    int len, npix, unit;
    bit timed_out;
    logic [7:0] px, py;
    if (op == OP_POINT) begin
      if (on_screen(x0, y0)) exp_q.push_back({K_PIX, x0, y0, c});
      return;
    end
    if (op == OP_RSVD) begin
      exp_q.push_back({K_OP, 24'h0});
      return;
    end
    if (op == OP_LINE) begin
      unit = 1;
      len  = line_hang ? 0 : int'((x1 ^ y1) & 8'd31) + 1;
    end else begin
      unit = 2;
      len  = 4 * int'(x1);
    end
    timed_out = (len == 0) || (len > TIMEOUT);
    npix      = timed_out ? TIMEOUT - 1 : len;
    en_q.push_back({2'(unit), 8'(timed_out ? TIMEOUT : len)});
    for (int k = 0; k < npix; k++) begin
      px = 8'(int'(x0) + k);
      py = (unit == 1) ? 8'(int'(y0) + 2 * k) : 8'(int'(y0) - k);
      if (on_screen(px, py)) exp_q.push_back({K_PIX, px, py, c});
    end
    if (timed_out) exp_q.push_back({K_TO, 24'h0});
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input logic [1:0] op, input logic [7:0] x0, input logic [7:0] y0,
                          input logic [7:0] x1, input logic [7:0] y1, input logic [7:0] c);
    int w = 0;
    @(negedge ACLK);
    while (!cmd_ready && w < 300) begin
      @(negedge ACLK);
      w++;
    end
    if (!cmd_ready) begin
      fail_now("push_wait");
      return;
    end
    cmd_op = op; cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1; cmd_color = c;
    cmd_valid = 1'b1;
    @(posedge ACLK);
    model_cmd(op, x0, y0, x1, y1, c);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    do begin
      @(negedge ACLK);
      w++;
    end while ((busy || exp_q.size() != 0 || en_q.size() != 0) && w < 3000);
    repeat (2) @(negedge ACLK);
    if (w >= 3000) fail_now("idle_wait");
  endtask

  // ---------------- monitor ----------------
  int          run_len = 0;
  int          gap_len = 100;
  logic [1:0]  run_unit = 2'd0;
  logic [1:0]  prev_unit = 2'd0;
  logic [15:0] prev_xy = 16'h0;

  task automatic sb_pop(input string name, input logic [25:0] got);
    logic [25:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected event 0x%0h, none required", name, got);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(got), 32'(e));
    end
  endtask

  always @(negedge ACLK) begin
    logic [9:0] e;
    if (flushing || !ARESETn) begin
      run_len   = 0;
      gap_len   = 100;
      prev_unit = 2'd0;
    end else begin
      if (pix_valid) begin
        sb_pop("pixel", {K_PIX, pix_x, pix_y, pix_color});
        if (prev_unit != 2'd0) check("pix_latency", 32'({pix_x, pix_y}), 32'(prev_xy));
      end
      if (err_op)      sb_pop("err_op", {K_OP, 24'h0});
      if (err_timeout) sb_pop("err_timeout", {K_TO, 24'h0});
      if (line_en || circle_en) begin
        if (run_len == 0) begin
          check("en_onehot", 32'(line_en & circle_en), 32'd0);
          check("en_gap_before_run", 32'(gap_len >= 3), 32'd1);
          run_unit = {circle_en, line_en};
        end
        run_len++;
      end else begin
        if (run_len != 0) begin
          if (en_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL en_run: unexpected enable unit %0d len %0d", run_unit, run_len);
          end else begin
            e = en_q.pop_front();
            check("en_run", 32'({run_unit, 8'(run_len)}), 32'(e));
          end
          gap_len = 0;
        end
        run_len = 0;
        gap_len++;
      end
      prev_unit = {circle_en, line_en};
      prev_xy   = circle_en ? {circle_x, circle_y} : {line_x, line_y};
    end
  end

  // ---------------- global bound ----------------
  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    cmd_valid = 1'b1; cmd_op = OP_POINT;
    cmd_x0 = 8'd9; cmd_y0 = 8'd9; cmd_x1 = 8'd0; cmd_y1 = 8'd0; cmd_color = 8'hFF;
    ARESETn = 1'b1;
    #1 ARESETn = 1'b0;
    repeat (3) @(negedge ACLK);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_line_en", 32'(line_en), 32'd0);
    check("rst_circle_en", 32'(circle_en), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_err_op", 32'(err_op), 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    cmd_valid = 1'b0;
    ARESETn   = 1'b1;
    flushing  = 1'b0;
    repeat (3) @(negedge ACLK);
    check("busy_after_reset", 32'(busy), 32'd0);

    // POINT at (3,7), busy back to 0 four edges after acceptance.
    push_cmd(OP_POINT, 8'd3, 8'd7, 8'd0, 8'd0, 8'h5A);
    n = 0;
    while (n < 20) begin
      @(posedge ACLK);
      n++;
      @(negedge ACLK);
      if (!busy) break;
    end
    check("point_busy_cycles", 32'(n), 32'd4);
    wait_idle();

    // CIRCLE R=5 (20 cycles) followed at once by a LINE.
    push_cmd(OP_CIRCLE, 8'd0, 8'd0, 8'd5, 8'd0, 8'h3C);
    push_cmd(OP_LINE, 8'd20, 8'd30, 8'd6, 8'd1, 8'h81);
    wait_idle();

    // Fill the FIFO while a 32-cycle LINE runs.
    push_cmd(OP_LINE, 8'd10, 8'd10, 8'd31, 8'd0, 8'h11);
    n = 0;
    while (!line_en && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (!line_en) fail_now("line_start_wait");
    push_cmd(OP_POINT, 8'd1, 8'd2, 8'd0, 8'd0, 8'h21);
    push_cmd(OP_CIRCLE, 8'd50, 8'd60, 8'd2, 8'd0, 8'h22);
    push_cmd(OP_RSVD, 8'd0, 8'd0, 8'd0, 8'd0, 8'h23);
    check("ready_before_full", 32'(cmd_ready), 32'd1);
    push_cmd(OP_LINE, 8'd5, 8'd6, 8'd3, 8'd0, 8'h24);
    check("ready_when_full", 32'(cmd_ready), 32'd0);
    push_cmd(OP_POINT, 8'd9, 8'd8, 8'd0, 8'd0, 8'h25);
    wait_idle();

    // LINE whose unit never finishes, then a normal command.
    line_hang = 1'b1;
    push_cmd(OP_LINE, 8'd5, 8'd5, 8'd3, 8'd4, 8'h77);
    push_cmd(OP_POINT, 8'd9, 8'd9, 8'd0, 8'd0, 8'h78);
    wait_idle();
    line_hang = 1'b0;

    // Reserved opcode, then an off-screen POINT (dropped only with clipping).
    push_cmd(OP_RSVD, 8'd1, 8'd1, 8'd1, 8'd1, 8'h99);
    push_cmd(OP_POINT, 8'd200, 8'd10, 8'd0, 8'd0, 8'h44);
    wait_idle();

    // Randomised mix.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [7:0] x1;
      op = 2'($urandom_range(0, 3));
      x1 = (op == OP_CIRCLE) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(0, 255));
      push_cmd(op, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), x1,
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) @(negedge ACLK);
    end
    wait_idle();

    // Asynchronous reset while a LINE runs with more commands queued.
    push_cmd(OP_LINE, 8'd10, 8'd10, 8'd31, 8'd0, 8'h11);
    push_cmd(OP_POINT, 8'd1, 8'd1, 8'd0, 8'd0, 8'h12);
    push_cmd(OP_CIRCLE, 8'd2, 8'd2, 8'd3, 8'd0, 8'h13);
    n = 0;
    while (!line_en && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (!line_en) fail_now("line_start_wait2");
    repeat (5) @(posedge ACLK);
    #2;
    flushing = 1'b1;
    ARESETn  = 1'b0;
    #1;
    check("async_rst_line_en", 32'(line_en), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_ready", 32'(cmd_ready), 32'd1);
    exp_q.delete();
    en_q.delete();
    repeat (3) @(negedge ACLK);
    ARESETn  = 1'b1;
    flushing = 1'b0;
    repeat (20) @(negedge ACLK);
    check("queue_discarded_busy", 32'(busy), 32'd0);
    check("queue_discarded_en", 32'({circle_en, line_en}), 32'd0);

    check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("final_en_q_empty", 32'(en_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
